// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two valid/ready requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    input  logic [3:0]            req0_ctrl_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    input  logic [3:0]            req1_ctrl_i,
    output logic                  rsp0_valid_o,
    input  logic                  rsp0_ready_i,
    output logic [DATA_WIDTH-1:0] rsp0_result_o,
    output logic                  rsp0_zero_o,
    output logic                  rsp0_err_o,
    output logic                  rsp1_valid_o,
    input  logic                  rsp1_ready_i,
    output logic [DATA_WIDTH-1:0] rsp1_result_o,
    output logic                  rsp1_zero_o,
    output logic                  rsp1_err_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [3:0]            alu_ctrl_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] grant0_cnt_o,
    output logic [STAT_WIDTH-1:0] grant1_cnt_o
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_reg;
    logic                  owner_reg;
    logic                  last_grant_reg;
    logic [DATA_WIDTH-1:0] alu_a_reg;
    logic [DATA_WIDTH-1:0] alu_b_reg;
    logic [3:0]            alu_ctrl_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic                  zero_reg;
    logic                  err_reg;
    logic                  rsp_valid_reg;

    logic [1:0] valid_vec;
    logic [1:0] ready_vec;
    logic       grant;
    logic       accept;
    logic       rsp_ready_sel;

    assign valid_vec = {req1_valid_i, req0_valid_i};

    // A tie goes to whichever requester was not granted last.
    assign grant = valid_vec[1] & (~valid_vec[0] | ~last_grant_reg);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_ready
            assign ready_vec[gi] = (state_reg == IDLE) & ~rst_i & valid_vec[gi]
                                   & (grant == gi[0]);
        end
    endgenerate

    assign accept        = |(valid_vec & ready_vec);
    assign rsp_ready_sel = owner_reg ? rsp1_ready_i : rsp0_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= '0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            err_reg        <= 1'b0;
            rsp_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_a_reg      <= grant ? req1_a_i : req0_a_i;
                        alu_b_reg      <= grant ? req1_b_i : req0_b_i;
                        alu_ctrl_reg   <= grant ? req1_ctrl_i : req0_ctrl_i;
                        owner_reg      <= grant;
                        last_grant_reg <= grant;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal op codes leave the ALU outputs undefined; never sample them.
                    if (alu_ctrl_reg >= 4'd10) begin
                        result_reg <= '0;
                        zero_reg   <= 1'b0;
                        err_reg    <= 1'b1;
                    end else begin
                        result_reg <= alu_result_i;
                        zero_reg   <= alu_zero_i;
                        err_reg    <= 1'b0;
                    end
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_sel) begin
                        rsp_valid_reg <= 1'b0;
                        err_reg       <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req0_ready_o  = ready_vec[0];
    assign req1_ready_o  = ready_vec[1];
    assign rsp0_valid_o  = rsp_valid_reg & ~owner_reg;
    assign rsp1_valid_o  = rsp_valid_reg & owner_reg;
    assign rsp0_result_o = result_reg;
    assign rsp1_result_o = result_reg;
    assign rsp0_zero_o   = zero_reg;
    assign rsp1_zero_o   = zero_reg;
    assign rsp0_err_o    = err_reg & ~owner_reg;
    assign rsp1_err_o    = err_reg & owner_reg;
    assign alu_a_o       = alu_a_reg;
    assign alu_b_o       = alu_b_reg;
    assign alu_ctrl_o    = alu_ctrl_reg;

`ifdef ALU_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [STAT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_reg <= '0;
                end else if (valid_vec[gi] && ready_vec[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign grant0_cnt_o = gen_cnt[0].cnt_reg;
    assign grant1_cnt_o = gen_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the alu_* port.
module tb_alu_arbiter;

    localparam int DW = 32;
`ifdef ALU_ARB_STATS_EN
    localparam int SW = 2;
`else
    localparam int SW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_ctrl = '0, req1_ctrl = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [DW-1:0] rsp0_result, rsp1_result;
    logic          rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [3:0]    alu_ctrl;
    logic          alu_zero;
`ifdef ALU_ARB_STATS_EN
    logic [SW-1:0] grant0_cnt, grant1_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_ctrl_i(req0_ctrl),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_ctrl_i(req1_ctrl),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp0_result_o(rsp0_result), .rsp0_zero_o(rsp0_zero), .rsp0_err_o(rsp0_err),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp1_result_o(rsp1_result), .rsp1_zero_o(rsp1_zero), .rsp1_err_o(rsp1_err),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero)
`ifdef ALU_ARB_STATS_EN
        , .grant0_cnt_o(grant0_cnt), .grant1_cnt_o(grant1_cnt)
`endif
    );

    // Op codes: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU; others give junk.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        alu_zero   = 1'b1;
        case (alu_ctrl)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = alu_a << alu_b[4:0];
            4'd6: alu_result = alu_a >> alu_b[4:0];
            4'd7: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd8: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd9: alu_result = {31'd0, alu_a < alu_b};
            default: ;
        endcase
        if (alu_ctrl < 4'd10) alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic set_req(input int who, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [3:0] c);
        if (who == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
        end
    endtask

    // Full transaction from IDLE: grant, EXEC, RESP held 'hold' cycles, handshake.
    task automatic do_op(input string tag, input int who, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [3:0] c,
                         input logic [DW-1:0] er, input logic ez, input logic ee,
                         input int hold);
        logic rv, ov, rz, re;
        logic [DW-1:0] rr;
        set_req(who, 1'b1, a, b, c);
        #1;
        check({tag, ".ready"}, (who == 0) ? req0_ready : req1_ready, 1);
        check({tag, ".other_ready"}, (who == 0) ? req1_ready : req0_ready, 0);
        tick();
        set_req(who, 1'b0, a, b, c);
        #1;
        check({tag, ".exec_ready"}, {req0_ready, req1_ready}, 0);
        check({tag, ".alu_a"}, alu_a, a);
        check({tag, ".alu_ctrl"}, alu_ctrl, c);
        for (int h = 0; h <= hold; h++) begin
            tick();
            #1;
            rv = (who == 0) ? rsp0_valid : rsp1_valid;
            ov = (who == 0) ? rsp1_valid : rsp0_valid;
            rr = (who == 0) ? rsp0_result : rsp1_result;
            rz = (who == 0) ? rsp0_zero : rsp1_zero;
            re = (who == 0) ? rsp0_err : rsp1_err;
            check({tag, ".rsp_valid"}, rv, 1);
            check({tag, ".other_rsp_valid"}, ov, 0);
            check({tag, ".result"}, rr, er);
            check({tag, ".zero"}, rz, ez);
            check({tag, ".err"}, re, ee);
            if (h < hold) check({tag, ".alu_a_hold"}, alu_a, a);
        end
        if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        #1;
        check({tag, ".rsp_done"}, (who == 0) ? rsp0_valid : rsp1_valid, 0);
        check({tag, ".err_clr"}, {rsp0_err, rsp1_err}, 0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        $display("txn %s req%0d ctrl=%0d a=%0h b=%0h -> result=%0h zero=%0b err=%0b",
                 tag, who, c, a, b, rr, rz, re);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        check("rst.ready", {req0_ready, req1_ready}, 0);
        check("rst.rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst.alu_a", alu_a, 0);
        check("rst.result", rsp0_result, 0);

        // Single request with a stalled consumer.
        do_op("add", 0, 32'd5, 32'd3, 4'd0, 32'd8, 1'b0, 1'b0, 3);

        // Both requesters valid continuously from reset: alternate 0,1,0,1.
        apply_reset();
        set_req(0, 1'b1, 32'd7, 32'd7, 4'd1);
        set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 4'd4);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = k % 2;
            #1;
            check("rr.ready0", req0_ready, (w == 0));
            check("rr.ready1", req1_ready, (w == 1));
            tick();
            #1;
            check("rr.exec_ready", {req0_ready, req1_ready}, 0);
            tick();
            #1;
            check("rr.rsp0_valid", rsp0_valid, (w == 0));
            check("rr.rsp1_valid", rsp1_valid, (w == 1));
            check("rr.result", (w == 0) ? rsp0_result : rsp1_result,
                  (w == 0) ? 32'd0 : 32'h0000_00FF);
            check("rr.zero", (w == 0) ? rsp0_zero : rsp1_zero, (w == 0));
            $display("txn rr req%0d result=%0h", w,
                     (w == 0) ? rsp0_result : rsp1_result);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // req1 alone, then a tie while it is being served.
        set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'd7);
        rsp1_ready = 1'b1;
        #1;
        check("sra.ready1", req1_ready, 1);
        check("sra.ready0", req0_ready, 0);
        tick();
        set_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
        #1;
        check("sra.exec_ready", {req0_ready, req1_ready}, 0);
        tick();
        #1;
        check("sra.rsp1_valid", rsp1_valid, 1);
        check("sra.result", rsp1_result, 32'hF800_0000);
        check("sra.zero", rsp1_zero, 0);
        $display("txn sra req1 result=%0h", rsp1_result);
        tick();
        #1;
        check("tie.ready0", req0_ready, 1);
        check("tie.ready1", req1_ready, 0);
        req1_valid = 1'b0;
        rsp1_ready = 1'b0;
        do_op("tie_add", 0, 32'd1, 32'd1, 4'd0, 32'd2, 1'b0, 1'b0, 0);

        // Illegal op code then a legal SLTU.
        do_op("illegal", 0, 32'd1, 32'd2, 4'd12, 32'd0, 1'b0, 1'b1, 1);
        do_op("sltu", 0, 32'd1, 32'd2, 4'd9, 32'd1, 1'b0, 1'b0, 0);

        // Asynchronous reset during EXEC.
        set_req(0, 1'b1, 32'd3, 32'd4, 4'd0);
        tick();
        set_req(0, 1'b0, 32'd3, 32'd4, 4'd0);
        #1;
        check("rst_exec.pre_alu_a", alu_a, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_exec.alu_a", alu_a, 0);
        check("rst_exec.alu_b", alu_b, 0);
        check("rst_exec.rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Asynchronous reset during RESP.
        set_req(0, 1'b1, 32'd9, 32'd9, 4'd1);
        tick();
        set_req(0, 1'b0, 32'd9, 32'd9, 4'd1);
        tick();
        #1;
        check("rst_resp.pre_valid", rsp0_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_resp.rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_resp.result", rsp0_result, 0);
        check("rst_resp.zero", rsp0_zero, 0);
        check("rst_resp.alu_a", alu_a, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_op("post_rst", 1, 32'd10, 32'd20, 4'd0, 32'd30, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst.no_stale_rsp", {rsp0_valid, rsp1_valid}, 0);
        end

`ifdef ALU_ARB_STATS_EN
        apply_reset();
        check("stats.rst0", grant0_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            do_op("stats", 0, i, 32'd1, 4'd0, i + 1, 1'b0, 1'b0, 0);
            if (i == 1) check("stats.two", grant0_cnt, 2);
        end
        check("stats.sat0", grant0_cnt, 3);
        check("stats.cnt1", grant1_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
